// File: rtl/pwm_duty_decoder_pkg.sv
// Shared types and width helpers for the PWM duty-cycle decoder.
package pwm_duty_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Counter width that can hold the timeout value itself
  function automatic int cnt_width(input int to);
    return $clog2(to + 1);
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: o_quot = floor(i_num / i_den), one quotient bit per cycle.
// Quotient saturates to all ones when the integer part of i_num >= i_den.
module pwm_duty_div #(
  parameter int N  = 8,
  parameter int CW = 9
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [CW+N-1:0] i_num,
  input  logic [CW-1:0]   i_den,
  output logic            o_busy,
  output logic            o_done,
  output logic [N-1:0]    o_quot
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] r_rem;
  logic [N-1:0]  r_num;
  logic [CW-1:0] r_den;
  logic [N-1:0]  r_quot;
  logic [SW-1:0] r_step;
  logic          r_sat;
  logic          r_busy;
  logic          r_done;

  logic [CW:0]   w_shift;
  logic          w_ge;
  logic [CW-1:0] w_diff;

  assign w_shift = {r_rem, r_num[N-1]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  // Remainder stays below the divisor, so the low CW bits of the difference are exact
  assign w_diff  = w_shift[CW-1:0] - r_den;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rem  <= '0;
      r_num  <= '0;
      r_den  <= '0;
      r_quot <= '0;
      r_step <= '0;
      r_sat  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
        r_rem  <= i_num[CW+N-1:N];
        r_num  <= i_num[N-1:0];
        r_den  <= i_den;
        r_sat  <= (i_num[CW+N-1:N] >= i_den);
        r_quot <= '0;
        r_step <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_ge ? w_diff : w_shift[CW-1:0];
        r_num  <= {r_num[N-2:0], 1'b0};
        r_quot <= r_sat ? '1 : {r_quot[N-2:0], w_ge};
        r_step <= r_step + 1'b1;
        if (r_step == SW'(N - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports duty as an N-bit code.
// Result appears N+1 cycles after a detected rise; a missing rise for TO cycles reports stuck.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int N                = 8,
  parameter int PERIOD_CLK_COUNT = 2000000,
  parameter int SYNC_STAGES      = 2,
  parameter int TIMEOUT_PERIODS  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_pwm,
  output logic [N-1:0] o_dutyCycle,
  output logic         o_valid,
  output logic         o_stuck
);

  localparam int            TO      = TIMEOUT_PERIODS * PERIOD_CLK_COUNT;
  localparam int            CW      = cnt_width(TO);
  localparam logic [CW-1:0] TO_LAST = CW'(TO - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_e                 r_state;
  logic [CW-1:0]          r_cnt_p;
  logic [CW-1:0]          r_cnt_h;
  logic [N-1:0]           r_duty;
  logic                   r_valid;
  logic                   r_stuck;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_start;
  logic                   w_timeout;
  logic                   w_busy;
  logic                   w_done;
  logic [N-1:0]           w_quot;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_s && !r_s_d;
  assign w_start = i_en && (r_state == ST_MEASURE) && w_rise && !w_busy;
  // A finishing division owns the output this cycle; the timeout fires on a later cycle
  assign w_timeout = (r_cnt_p >= TO_LAST) && !w_done;

  pwm_duty_div #(
    .N  (N),
    .CW (CW)
  ) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_abort (!i_en),
    .i_num   ({r_cnt_h, {N{1'b0}}}),
    .i_den   (r_cnt_p),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync  <= '0;
      r_s_d   <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt_p <= '0;
      r_cnt_h <= '0;
      r_duty  <= '0;
      r_valid <= 1'b0;
      r_stuck <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_d   <= w_s;
      r_valid <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_cnt_p <= '0;
        r_cnt_h <= '0;
        r_stuck <= 1'b0;
      end else begin
        if (w_done) begin
          r_duty  <= w_quot;
          r_valid <= 1'b1;
          r_stuck <= 1'b0;
        end
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_cnt_p <= '0;
            r_cnt_h <= '0;
          end
          ST_ARM, ST_MEASURE: begin
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_cnt_p <= CW'(1);
              r_cnt_h <= CW'(1);
            end else if (w_timeout) begin
              r_state <= ST_ARM;
              r_cnt_p <= '0;
              r_cnt_h <= '0;
              r_duty  <= w_s ? '1 : '0;
              r_valid <= 1'b1;
              r_stuck <= 1'b1;
            end else begin
              r_cnt_p <= r_cnt_p + 1'b1;
              if (r_state == ST_MEASURE) r_cnt_h <= r_cnt_h + CW'(w_s);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_dutyCycle = r_duty;
  assign o_valid     = r_valid;
  assign o_stuck     = r_stuck;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench: a cycle-level reference of the PWM waveform predicts each duty report and its arrival cycle.
module tb_pwm_duty_decoder;

  localparam int N   = 8;
  localparam int PER = 100;
  localparam int TO  = 2 * PER;
  localparam int LAT = 12;   // input rise -> o_valid: 2 sync + 1 edge detect + N+1 divide
  localparam int EDL = 3;    // input change -> seen by the measurement logic

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         pwm = 1'b0;
  logic [N-1:0] duty;
  logic         valid;
  logic         stuck;

  pwm_duty_decoder #(
    .N                (N),
    .PERIOD_CLK_COUNT (PER),
    .SYNC_STAGES      (2),
    .TIMEOUT_PERIODS  (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_en        (en),
    .i_pwm       (pwm),
    .o_dutyCycle (duty),
    .o_valid     (valid),
    .o_stuck     (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at_cyc;
    int duty;
    bit stuck;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state, expressed in input-cycle time
  bit m_prev      = 1'b0;
  bit m_meas      = 1'b0;
  bit m_en_on     = 1'b1;
  int m_tlast     = 0;
  int m_hcnt      = 0;
  int m_laststart = -1000;
  int m_deadline  = 1 << 30;
  int m_out_duty  = 0;

  function automatic void check(string name, int act, int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endfunction

  function automatic void push(int at, int d, bit s);
    exp_t e;
    e.at_cyc = at;
    e.duty   = d;
    e.stuck  = s;
    q.push_back(e);
  endfunction

  function automatic void drop_from(int at);
    exp_t keep[$];
    foreach (q[i]) if (q[i].at_cyc < at) keep.push_back(q[i]);
    q = keep;
  endfunction

  function automatic void model_step(bit lvl, int t);
    bit rise;
    int p;
    int d;
    rise    = lvl && !m_prev;
    m_en_on = 1'b1;
    if (rise) begin
      if (m_meas) begin
        p = t - m_tlast;
        if (t - m_laststart >= N + 1) begin
          d = (m_hcnt * 256) / p;
          if (d > 255) d = 255;
          push(t + LAT, d, 1'b0);
          m_laststart = t;
        end
      end
      m_meas     = 1'b1;
      m_tlast    = t;
      m_hcnt     = 0;
      m_deadline = t + TO - 1;
    end else if (t == m_deadline) begin
      push(t + EDL, lvl ? 255 : 0, 1'b1);
      m_meas     = 1'b0;
      m_deadline = t + TO;
    end
    if (m_meas) m_hcnt += int'(lvl);
    m_prev = lvl;
  endfunction

  function automatic void model_halt(bit lvl, int t, bit is_reset);
    if (is_reset || m_en_on) drop_from(t + 1);
    m_en_on    = 1'b0;
    m_meas     = 1'b0;
    m_deadline = t + TO - 1;
    m_prev     = is_reset ? 1'b0 : lvl;
    if (is_reset) m_out_duty = 0;
  endfunction

  task automatic tick(input bit lvl, input bit r, input bit e);
    @(posedge clk);
    #1;
    pwm   = lvl;
    rst_n = r;
    en    = e;
    if (!r)      model_halt(lvl, cyc, 1'b1);
    else if (!e) model_halt(lvl, cyc, 1'b0);
    else         model_step(lvl, cyc);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) tick(1'b1, 1'b1, 1'b1);
      repeat (lo) tick(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got duty=%0d stuck=%0d required no valid (cycle %0d)",
                   duty, stuck, cyc);
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.at_cyc);
          check("duty", int'(duty), e.duty);
          check("stuck", int'(stuck), int'(e.stuck));
          m_out_duty = e.duty;
        end
      end
    end
  end

  initial begin
    int p;
    int h;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_stuck", int'(stuck), 0);

    wave(25, 75, 5);            // 64
    wave(50, 50, 3);            // 128
    wave(13, 87, 3);            // 33
    wave(25, 75, 2);
    wave(10, 40, 3);            // period change -> 51
    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(180, 20);
      h = $urandom_range(p - 1, 1);
      wave(h, p - h, 2);
    end
    wave(2, 4, 6);              // periods below N+1 drop every other sample
    wave(4, 8, 3);

    wave(25, 75, 3);
    repeat (450) tick(1'b0, 1'b1, 1'b1);
    check("stuck_low_flag", int'(stuck), 1);
    repeat (450) tick(1'b1, 1'b1, 1'b1);
    wave(25, 75, 3);

    wave(25, 75, 2);
    repeat (5) tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);     // reset while the divider is running
    tick(1'b1, 1'b1, 1'b1);
    check("rst_mid_div_duty", int'(duty), 0);
    repeat (19) tick(1'b1, 1'b1, 1'b1);
    repeat (75) tick(1'b0, 1'b1, 1'b1);
    wave(25, 75, 3);

    wave(25, 75, 2);
    repeat (25) tick(1'b1, 1'b1, 1'b1);
    repeat (30) tick(1'b0, 1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b1, 1'b0);
    check("en_off_stuck", int'(stuck), 0);
    check("en_off_duty_hold", int'(duty), m_out_duty);
    repeat (35) tick(1'b0, 1'b1, 1'b1);
    wave(25, 75, 3);

    repeat (30) tick(1'b0, 1'b1, 1'b1);
    check("pending_results", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
